// File: rtl/bank_cmd_stats_collector.sv
`default_nettype none
// ============================================================================
// Module  : bank_cmd_stats_collector
// Brief   : Snoops DRAM bank commands into saturating per-bank counters with
//           open-row tracking, illegal-command flagging and a 1-cycle read port.
// Revision: 1.0
// ============================================================================
module bank_cmd_stats_collector #(
  parameter int NUM_RANKS      = 1,
  parameter int NUM_BANKGROUPS = 4,
  parameter int NUM_BANKS      = 4,
  parameter int CNT_WIDTH      = 32,
  parameter int ROW_WIDTH      = 16,
  localparam int NB    = NUM_RANKS * NUM_BANKGROUPS * NUM_BANKS,
  localparam int RK_W  = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1,
  localparam int BG_W  = (NUM_BANKGROUPS > 1) ? $clog2(NUM_BANKGROUPS) : 1,
  localparam int BK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_fire,
  input  logic                 cs,
  input  logic                 ras,
  input  logic                 cas,
  input  logic                 we,
  input  logic [RK_W-1:0]      cmd_rank,
  input  logic [BG_W-1:0]      cmd_bankgroup,
  input  logic [BK_W-1:0]      cmd_bank,
  input  logic [ROW_WIDTH-1:0] cmd_row,
  input  logic                 clear,
  input  logic                 rd_en,
  input  logic [IDX_W-1:0]     rd_idx,
  input  logic [2:0]           rd_sel,
  output logic                 rd_valid,
  output logic [CNT_WIDTH-1:0] rd_data,
  output logic                 err_sticky
);

  localparam logic [2:0] SEL_ACT    = 3'd0;
  localparam logic [2:0] SEL_PRE    = 3'd1;
  localparam logic [2:0] SEL_RD     = 3'd2;
  localparam logic [2:0] SEL_WR     = 3'd3;
  localparam logic [2:0] SEL_REF    = 3'd4;
  localparam logic [2:0] SEL_ILL    = 3'd5;
  localparam logic [2:0] SEL_OPEN   = 3'd6;
  localparam logic [2:0] SEL_STATUS = 3'd7;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] cnt       [NB][7];
  logic                 bank_open [NB];
  logic [ROW_WIDTH-1:0] open_row  [NB];

  logic             cmd_valid;
  logic [2:0]       cmd_sel;
  logic [31:0]      flat_idx;
  logic [IDX_W-1:0] tgt;
  logic             tgt_open;
  logic             cmd_illegal;
  logic [CNT_WIDTH-1:0] rd_mux;

  // The command's counter select doubles as the rd_sel code of its counter.
  always_comb begin
    cmd_valid = 1'b0;
    cmd_sel   = SEL_ACT;
    if (cmd_fire && !cs) begin
      cmd_valid = 1'b1;
      case ({ras, cas, we})
        3'b001:  cmd_sel = SEL_REF;
        3'b010:  cmd_sel = SEL_PRE;
        3'b011:  cmd_sel = SEL_ACT;
        3'b101:  cmd_sel = SEL_RD;
        3'b100:  cmd_sel = SEL_WR;
        default: cmd_valid = 1'b0;
      endcase
    end
    flat_idx = 32'(cmd_rank) * NUM_BANKGROUPS * NUM_BANKS
             + 32'(cmd_bankgroup) * NUM_BANKS + 32'(cmd_bank);
    if (flat_idx >= 32'(NB)) cmd_valid = 1'b0;
    tgt      = flat_idx[IDX_W-1:0];
    tgt_open = bank_open[tgt];

    cmd_illegal = 1'b0;
    if (cmd_valid) begin
      case (cmd_sel)
        SEL_ACT, SEL_REF: cmd_illegal = tgt_open;
        SEL_RD, SEL_WR:   cmd_illegal = !tgt_open;
        default:          cmd_illegal = 1'b0;
      endcase
    end
  end

  // Bank state follows legal commands even when clear suppresses counting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < NB; b++) begin
        bank_open[b] <= 1'b0;
        open_row[b]  <= '0;
        for (int s = 0; s < 7; s++) cnt[b][s] <= '0;
      end
      err_sticky <= 1'b0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (clear) begin
          for (int s = 0; s < 7; s++) cnt[b][s] <= '0;
        end else if (bank_open[b] && cnt[b][SEL_OPEN] != CNT_MAX) begin
          cnt[b][SEL_OPEN] <= cnt[b][SEL_OPEN] + 1'b1;
        end
      end

      if (cmd_valid) begin
        if (cmd_illegal) begin
          if (!clear) begin
            err_sticky <= 1'b1;
            if (cnt[tgt][SEL_ILL] != CNT_MAX) cnt[tgt][SEL_ILL] <= cnt[tgt][SEL_ILL] + 1'b1;
          end
        end else begin
          if (cmd_sel == SEL_ACT) begin
            bank_open[tgt] <= 1'b1;
            open_row[tgt]  <= cmd_row;
          end else if (cmd_sel == SEL_PRE) begin
            bank_open[tgt] <= 1'b0;
          end
          if (!clear && cnt[tgt][cmd_sel] != CNT_MAX) cnt[tgt][cmd_sel] <= cnt[tgt][cmd_sel] + 1'b1;
        end
      end

      if (clear) err_sticky <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (32'(rd_idx) < 32'(NB)) begin
      if (rd_sel == SEL_STATUS) rd_mux = CNT_WIDTH'({bank_open[rd_idx], open_row[rd_idx]});
      else                      rd_mux = cnt[rd_idx][rd_sel];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end

endmodule
`default_nettype wire

// File: doc/bank_cmd_stats_collector.md
# bank_cmd_stats_collector

Synthesizable, parametrised per-bank DRAM command statistics collector. It sits beside the bank command path and snoops every issued command. It decodes the cs/ras/cas/we encoding into saturating per-bank event counters, tracks per-bank open-row state, and flags protocol-illegal commands. A single-cycle read port exposes the counters to the host debug interface, replacing file-based simulation logging with on-chip counters.

## Interface
- NUM_RANKS, 1, ranks tracked
- NUM_BANKGROUPS, 4, bank groups per rank
- NUM_BANKS, 4, banks per bank group
- CNT_WIDTH, 32, width of every counter (≥8)
- ROW_WIDTH, 16, row address width
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cmd_fire  in  1  command issued this cycle
- cs, ras, cas, we  in  1 each  command pins (active-low encoding)
- cmd_rank  in  $clog2(NUM_RANKS) (min 1)  target rank
- cmd_bankgroup  in  $clog2(NUM_BANKGROUPS) (min 1)  target bank group
- cmd_bank  in  $clog2(NUM_BANKS) (min 1)  target bank
- cmd_row  in  ROW_WIDTH  row address, meaningful on ACT
- clear  in  1  synchronous clear of all counters and the error flag
- rd_en  in  1  counter read request
- rd_idx  in  $clog2(NB) (min 1)  flat bank index, NB = NUM_RANKS*NUM_BANKGROUPS*NUM_BANKS
- rd_sel  in  3  counter select
- rd_valid  out  1  read response valid
- rd_data  out  CNT_WIDTH  read response data
- err_sticky  out  1  set on the first illegal command

## Operation
- Flat index = rank*NUM_BANKGROUPS*NUM_BANKS + bankgroup*NUM_BANKS + bank.
- Decode when cmd_fire=1 and cs=0, using {ras,cas,we}:
  - 001 REF
  - 010 PRE
  - 011 ACT
  - 101 RD
  - 100 WR
- All other encodings, cs=1, or cmd_fire=0 are NOP and are ignored.
- Per-bank state: open bit and open_row.
  - ACT to a closed bank: open=1, open_row=cmd_row, ACT count +1.
  - PRE: open=0, PRE count +1. PRE to a closed bank is legal.
  - RD/WR to an open bank: RD or WR count +1.
  - REF to a closed bank: REF count +1.
- Illegal commands: ACT to an open bank, RD/WR to a closed bank, REF to an open bank.
  - ILLEGAL count +1 and err_sticky set.
  - Type counter and bank state are unchanged.
- OPEN_CYCLES: +1 on every edge at which the bank's open bit was 1 before the edge.
- All counters saturate at 2^CNT_WIDTH−1. They never wrap.
- Commands with a flat index ≥ NB are ignored: no count, no flag.
- rd_sel codes:
  - 0 ACT, 1 PRE, 2 RD, 3 WR, 4 REF, 5 ILLEGAL, 6 OPEN_CYCLES
  - 7 status = {zero-extended, open, open_row}, truncated to CNT_WIDTH
- rd_idx ≥ NB returns 0.
- clear zeroes all counters and err_sticky. Bank open state and open_row are preserved.

## Timing
- Reset (reset=0, asynchronous):
  - all counters 0, all banks closed, open_row 0
  - err_sticky 0, rd_valid 0, rd_data 0
- Counter and state updates take effect at the clk edge sampling cmd_fire.
- Read latency is 1 cycle. rd_en sampled at edge N gives rd_valid=1 and rd_data after edge N.
  - rd_valid=0 when rd_en was 0 at the previous edge.
  - rd_data holds its last value.
- Back-to-back reads are accepted every cycle. There is no backpressure.
- A read in the same cycle as an update returns the pre-update value.
- clear together with cmd_fire:
  - clear wins for counters and err_sticky; the command is not counted.
  - The command still updates bank open state.
- clear together with rd_en returns the pre-clear value.
- Reset deasserting mid-operation: the first command after release is decoded against the closed state.
- Exactly one counter per bank changes per command, plus OPEN_CYCLES.

## Test plan
- Reset, then ACT (rank0, bg1, bank2, row 0x1234), 3× RD, 2× WR, PRE, then read idx 6:
  - ACT=1, RD=3, WR=2, PRE=1
  - status before PRE = 0x11234, after PRE = 0x01234
  - ILLEGAL=0, err_sticky=0
- ACT to idx 0, ACT again, RD to closed idx 1:
  - idx0 ACT=1; ILLEGAL idx0=1, idx1=1
  - err_sticky=1 after the second ACT edge; idx1 RD=0
- ACT idx 3, wait 10 idle cycles, PRE → OPEN_CYCLES idx3 = 11 (open from the ACT edge through the PRE edge).
- CNT_WIDTH=8, 300 PRE to idx 2 → PRE reads 255, not 44.
- clear asserted in the same cycle as RD to an open bank:
  - RD count reads 0, err_sticky=0
  - bank stays open; status unchanged
- Assert reset asynchronously mid-burst between edges:
  - rd_valid drops immediately; all reads return 0
  - next RD without ACT counts as ILLEGAL
